// File: rtl/organ_pkg.sv
// Shared encodings for the organ: song ROM entry layout, sequencer states
// and the one-hot key/octave decoders used by both the sequencer and play.
package organ_pkg;

    localparam logic [2:0] NOTE_REST = 3'd0;
    localparam logic [1:0] OCT_LOW   = 2'd0;
    localparam logic [1:0] OCT_MID   = 2'd1;
    localparam logic [1:0] OCT_HIGH  = 2'd2;
    localparam logic [2:0] DUR_END   = 3'd0;

    // Entry bits: [7:5] note, [4:3] octave, [2:0] duration in ticks
    typedef struct packed {
        logic [2:0] note;
        logic [1:0] oct;
        logic [2:0] dur;
    } songEntry_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } seqState_e;

    function automatic logic [6:0] noteKey(input logic [2:0] note);
        if (note == NOTE_REST) return 7'b0;
        return 7'(7'b1000000 >> (note - 3'd1));
    endfunction

    // Octave code 3 is unused and plays as mid; a rest selects no octave
    function automatic logic [2:0] octSel(input logic [2:0] note, input logic [1:0] oct);
        if (note == NOTE_REST) return 3'b000;
        case (oct)
            OCT_LOW:  return 3'b001;
            OCT_HIGH: return 3'b100;
            default:  return 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/organ_song_sequencer_if.sv
// Auto-play control and key/octave outputs between sequencer and play stage.
interface organ_song_sequencer_if;
    logic       auto_sw;
    logic [6:0] key;
    logic [2:0] oct;
    logic       busy;
    logic [4:0] song_pos;

    modport master (input auto_sw, output key, oct, busy, song_pos);
    modport slave  (output auto_sw, input key, oct, busy, song_pos);
endinterface

// File: rtl/song_rom.sv
// Built-in song: 32 x 8 combinational ROM; unused addresses read as end marker.
module song_rom
    import organ_pkg::*;
(
    input  logic [4:0] addr,
    output songEntry_t entry
);

    always_comb begin
        entry = '{note: NOTE_REST, oct: OCT_LOW, dur: DUR_END};
        case (addr)
            5'd0: entry = '{note: 3'd3,      oct: OCT_MID,  dur: 3'd2};
            5'd1: entry = '{note: NOTE_REST, oct: OCT_LOW,  dur: 3'd1};
            5'd2: entry = '{note: 3'd7,      oct: OCT_HIGH, dur: 3'd1};
            default: ;
        endcase
    end

endmodule

// File: rtl/organ_song_sequencer.sv
// Auto-play sequencer: steps through song_rom, pacing notes and gaps with a tempo tick.
module organ_song_sequencer
    import organ_pkg::*;
#(
    parameter int TICK_DIV  = 6_250_000,
    parameter int GAP_TICKS = 1,
    parameter int SONG_LEN  = 32
) (
    input logic                    clk,
    input logic                    rst_n,
    organ_song_sequencer_if.master bus
);

    localparam int              CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [2:0]      GAP_LAST  = 3'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam bit              HAS_GAP   = (GAP_TICKS > 0);
    localparam logic [4:0]      LAST_POS  = 5'(SONG_LEN - 1);

    seqState_e   state;
    logic [CW-1:0] cycCnt;
    logic [2:0]  tickCnt;
    logic [2:0]  curDur;
    logic [6:0]  keyReg;
    logic [2:0]  octReg;
    logic        busyReg;
    logic [4:0]  posReg;

    logic [4:0]  incPos;
    songEntry_t  nextEntry;
    songEntry_t  firstEntry;
    songEntry_t  selEntry;
    logic [4:0]  selPos;
    logic [2:0]  selDur;
    logic        tick;
    logic        playDone;
    logic        gapDone;
    logic        doLoad;

    // Wrapping at the last slot never presents an out-of-range address
    assign incPos = (posReg == LAST_POS) ? 5'd0 : posReg + 5'd1;

    song_rom u_romNext  (.addr(incPos), .entry(nextEntry));
    song_rom u_romFirst (.addr(5'd0),   .entry(firstEntry));

    // Entry 0 being an end marker plays as a one-tick rest so the loop never stalls
    always_comb begin
        selEntry = nextEntry;
        selPos   = incPos;
        if (state == IDLE || nextEntry.dur == DUR_END) begin
            selEntry = firstEntry;
            selPos   = 5'd0;
        end
        selDur = selEntry.dur;
        if (selEntry.dur == DUR_END) begin
            selEntry.note = NOTE_REST;
            selDur        = 3'd1;
        end
    end

    assign tick     = (cycCnt == TICK_LAST);
    assign playDone = tick && (tickCnt == curDur - 3'd1);
    assign gapDone  = tick && (tickCnt == GAP_LAST);
    assign doLoad   = (state == IDLE)
                   || (state == PLAY && playDone && !HAS_GAP)
                   || (state == GAP && gapDone);

    always_ff @(posedge clk) begin
        if (!rst_n || !bus.auto_sw) begin
            state   <= IDLE;
            cycCnt  <= '0;
            tickCnt <= '0;
            curDur  <= '0;
            keyReg  <= '0;
            octReg  <= '0;
            busyReg <= 1'b0;
            posReg  <= '0;
        end else if (doLoad) begin
            state   <= PLAY;
            cycCnt  <= '0;
            tickCnt <= '0;
            curDur  <= selDur;
            keyReg  <= noteKey(selEntry.note);
            octReg  <= octSel(selEntry.note, selEntry.oct);
            busyReg <= 1'b1;
            posReg  <= selPos;
        end else if (state == PLAY && playDone) begin
            state   <= GAP;
            cycCnt  <= '0;
            tickCnt <= '0;
            keyReg  <= '0;
            octReg  <= '0;
        end else begin
            cycCnt <= tick ? '0 : CW'(cycCnt + 1'b1);
            if (tick) tickCnt <= tickCnt + 3'd1;
        end
    end

    assign bus.key      = keyReg;
    assign bus.oct      = octReg;
    assign bus.busy     = busyReg;
    assign bus.song_pos = posReg;

endmodule

// File: tb/tb_organ_song_sequencer.sv
// Directed bench for organ_song_sequencer: default, no-gap and two-entry song configurations.
module tb_organ_song_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] autoVec;
    int         testCount = 0;
    int         failCount = 0;

    organ_song_sequencer_if busA ();
    organ_song_sequencer_if busB ();
    organ_song_sequencer_if busC ();

    assign busA.auto_sw = autoVec[0];
    assign busB.auto_sw = autoVec[1];
    assign busC.auto_sw = autoVec[2];

    organ_song_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .SONG_LEN(32)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
    organ_song_sequencer #(.TICK_DIV(4), .GAP_TICKS(0), .SONG_LEN(32)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));
    organ_song_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .SONG_LEN(2))  dutC (.clk(clk), .rst_n(rst_n), .bus(busC));

    always #5 clk = ~clk;

    logic [6:0] keyObs  [3];
    logic [2:0] octObs  [3];
    logic       busyObs [3];
    logic [4:0] posObs  [3];

    assign keyObs[0] = busA.key;      assign keyObs[1] = busB.key;      assign keyObs[2] = busC.key;
    assign octObs[0] = busA.oct;      assign octObs[1] = busB.oct;      assign octObs[2] = busC.oct;
    assign busyObs[0] = busA.busy;    assign busyObs[1] = busB.busy;    assign busyObs[2] = busC.busy;
    assign posObs[0] = busA.song_pos; assign posObs[1] = busB.song_pos; assign posObs[2] = busC.song_pos;

    localparam logic [6:0] K3 = 7'b0010000;
    localparam logic [6:0] K7 = 7'b0000001;
    localparam logic [2:0] OMID = 3'b010;
    localparam logic [2:0] OHIGH = 3'b100;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change #1 after a rising edge, so the next edge samples them
    task automatic applyStimulus(input logic rstVal, input logic [2:0] autoVal);
        rst_n   = rstVal;
        autoVec = autoVal;
    endtask

    task automatic checkRun(input int inst, input int n, input logic [6:0] k, input logic [2:0] o,
                            input logic b, input logic [4:0] p, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s.key[%0d]", tag, i),  32'(keyObs[inst]),  32'(k));
            checkOutput($sformatf("%s.oct[%0d]", tag, i),  32'(octObs[inst]),  32'(o));
            checkOutput($sformatf("%s.busy[%0d]", tag, i), 32'(busyObs[inst]), 32'(b));
            checkOutput($sformatf("%s.pos[%0d]", tag, i),  32'(posObs[inst]),  32'(p));
        end
    endtask

    initial begin
        applyStimulus(1'b0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        checkRun(0, 1, 7'b0, 3'b0, 1'b0, 5'd0, "A.reset");
        applyStimulus(1'b1, 3'b000);
        checkRun(0, 2, 7'b0, 3'b0, 1'b0, 5'd0, "A.idle");

        // Full pass through the song and the wrap back to entry 0
        applyStimulus(1'b1, 3'b001);
        checkRun(0, 8, K3, OMID, 1'b1, 5'd0, "A.note3");
        checkRun(0, 4, 7'b0, 3'b0, 1'b1, 5'd0, "A.gap0");
        checkRun(0, 4, 7'b0, 3'b0, 1'b1, 5'd1, "A.rest");
        checkRun(0, 4, 7'b0, 3'b0, 1'b1, 5'd1, "A.gap1");
        checkRun(0, 4, K7, OHIGH, 1'b1, 5'd2, "A.note7");
        checkRun(0, 4, 7'b0, 3'b0, 1'b1, 5'd2, "A.gap2");
        checkRun(0, 2, K3, OMID, 1'b1, 5'd0, "A.wrap");

        applyStimulus(1'b1, 3'b000);
        checkRun(0, 1, 7'b0, 3'b0, 1'b0, 5'd0, "A.drop");
        applyStimulus(1'b1, 3'b001);
        checkRun(0, 8, K3, OMID, 1'b1, 5'd0, "A.restart");
        checkRun(0, 2, 7'b0, 3'b0, 1'b1, 5'd0, "A.gapPre");

        applyStimulus(1'b0, 3'b001);
        checkRun(0, 1, 7'b0, 3'b0, 1'b0, 5'd0, "A.rstGap");
        applyStimulus(1'b1, 3'b001);
        checkRun(0, 8, K3, OMID, 1'b1, 5'd0, "A.afterRst");
        checkRun(0, 4, 7'b0, 3'b0, 1'b1, 5'd0, "A.gapAfter");
        applyStimulus(1'b1, 3'b000);
        checkRun(0, 1, 7'b0, 3'b0, 1'b0, 5'd0, "A.off");

        // No gap: notes abut directly
        applyStimulus(1'b1, 3'b010);
        checkRun(1, 8, K3, OMID, 1'b1, 5'd0, "B.note3");
        checkRun(1, 4, 7'b0, 3'b0, 1'b1, 5'd1, "B.rest");
        checkRun(1, 4, K7, OHIGH, 1'b1, 5'd2, "B.note7");
        checkRun(1, 2, K3, OMID, 1'b1, 5'd0, "B.wrap");
        applyStimulus(1'b1, 3'b000);
        checkRun(1, 1, 7'b0, 3'b0, 1'b0, 5'd0, "B.off");

        // Two-entry song wraps after entry 1
        applyStimulus(1'b1, 3'b100);
        checkRun(2, 8, K3, OMID, 1'b1, 5'd0, "C.note3");
        checkRun(2, 4, 7'b0, 3'b0, 1'b1, 5'd0, "C.gap0");
        checkRun(2, 4, 7'b0, 3'b0, 1'b1, 5'd1, "C.rest");
        checkRun(2, 4, 7'b0, 3'b0, 1'b1, 5'd1, "C.gap1");
        checkRun(2, 8, K3, OMID, 1'b1, 5'd0, "C.wrap");
        applyStimulus(1'b1, 3'b000);
        checkRun(2, 1, 7'b0, 3'b0, 1'b0, 5'd0, "C.off");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
